// File: rtl/electrode_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : electrode_seq_pkg
// Brief    : Shared state encoding and watchdog limit for the sequencer.
// Revision : 1.0
// ============================================================================
package electrode_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_FIN = 3'd3,
        ST_DWELL    = 3'd4,
        ST_DONE     = 3'd5
    } seq_state_e;

    // Full serial shift plus margin before the serializer is declared hung.
    function automatic int timeout_cycles(input int n_electrodes);
        return 2 * n_electrodes + 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/electrode_pattern_ram.sv
`default_nettype none
// ============================================================================
// Module   : electrode_pattern_ram
// Brief    : Pattern table, synchronous write / combinational read, no reset.
// Revision : 1.0
// ============================================================================
module electrode_pattern_ram
    import electrode_seq_pkg::*;
#(
    parameter int N_ELECTRODES = 31,
    parameter int N_PATTERNS   = 8,
    parameter int IDX_W        = $clog2(N_PATTERNS)
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        waddr_i,
    input  logic [N_ELECTRODES-1:0] wdata_i,
    input  logic [IDX_W-1:0]        raddr_i,
    output logic [N_ELECTRODES-1:0] rdata_o
);

    logic [N_ELECTRODES-1:0] mem_q [N_PATTERNS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/electrode_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : electrode_config_sequencer
// Brief    : Feeds a table of electrode patterns to serializer_mod one by one.
//            Optional WAIT_FIN watchdog + timeout_err port: SEQ_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module electrode_config_sequencer
    import electrode_seq_pkg::*;
#(
    parameter int N_ELECTRODES = 31,
    parameter int N_PATTERNS   = 8,
    parameter int DWELL_W      = 16,
    parameter int IDX_W        = $clog2(N_PATTERNS),
    parameter int CNT_W        = $clog2(N_PATTERNS + 1)
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    loop_en,
    input  logic [CNT_W-1:0]        n_patterns_cfg,
    input  logic [DWELL_W-1:0]      dwell_cycles,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_addr,
    input  logic [N_ELECTRODES-1:0] wr_data,
    input  logic                    ser_sr_finish,
    output logic                    ser_enable_desp,
    output logic [N_ELECTRODES-1:0] electr_config_out,
    output logic [IDX_W-1:0]        pattern_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    wr_err
`ifdef SEQ_TIMEOUT_EN
    ,
    output logic                    timeout_err
`endif
);

    seq_state_e              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic                    loop_q, loop_d;
    logic [DWELL_W-1:0]      dwell_q, dwell_d;
    logic [DWELL_W-1:0]      dwell_cnt_q, dwell_cnt_d;
    logic                    stop_pend_q, stop_pend_d;
    logic                    ser_en_q, ser_en_d;
    logic [N_ELECTRODES-1:0] cfg_q, cfg_d;
    logic [IDX_W-1:0]        pidx_q, pidx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    wr_err_q, wr_err_d;
    logic [N_ELECTRODES-1:0] rd_data;
    logic [DWELL_W-1:0]      dwell_lim;

`ifdef SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(timeout_cycles(N_ELECTRODES));
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(timeout_cycles(N_ELECTRODES) - 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            tmo_q, tmo_d;
`endif

    electrode_pattern_ram #(
        .N_ELECTRODES (N_ELECTRODES),
        .N_PATTERNS   (N_PATTERNS),
        .IDX_W        (IDX_W)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (wr_en & ~busy_q),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (idx_q),
        .rdata_o (rd_data)
    );

    // A zero dwell still spends one counted cycle in DWELL.
    assign dwell_lim = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        last_d      = last_q;
        loop_d      = loop_q;
        dwell_d     = dwell_q;
        dwell_cnt_d = dwell_cnt_q;
        stop_pend_d = stop_pend_q | (busy_q & stop);
        cfg_d       = cfg_q;
        pidx_d      = pidx_q;
`ifdef SEQ_TIMEOUT_EN
        wd_cnt_d    = (state_q == ST_WAIT_FIN) ? wd_cnt_q + 1'b1 : '0;
        tmo_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && (n_patterns_cfg != '0)) begin
                    idx_d       = '0;
                    stop_pend_d = 1'b0;
                    loop_d      = loop_en;
                    dwell_d     = dwell_cycles;
                    last_d      = (n_patterns_cfg > CNT_W'(N_PATTERNS))
                                ? IDX_W'(N_PATTERNS - 1)
                                : IDX_W'(n_patterns_cfg - CNT_W'(1));
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cfg_d   = rd_data;
                pidx_d  = idx_q;
                state_d = stop_pend_q ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: state_d = ST_WAIT_FIN;
            ST_WAIT_FIN: begin
                if (ser_sr_finish) begin
                    dwell_cnt_d = '0;
                    state_d     = stop_pend_q ? ST_DONE : ST_DWELL;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wd_cnt_q == WD_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DWELL: begin
                if (dwell_cnt_q == dwell_lim) begin
                    if (stop_pend_q) begin
                        state_d = ST_DONE;
                    end else if (idx_q == last_q) begin
                        idx_d   = '0;
                        state_d = loop_q ? ST_LOAD : ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                stop_pend_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        ser_en_d = (state_d == ST_ISSUE);
        busy_d   = (state_d inside {ST_LOAD, ST_ISSUE, ST_WAIT_FIN, ST_DWELL});
        done_d   = (state_d == ST_DONE);
        wr_err_d = wr_en & busy_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            last_q      <= '0;
            loop_q      <= 1'b0;
            dwell_q     <= '0;
            dwell_cnt_q <= '0;
            stop_pend_q <= 1'b0;
            ser_en_q    <= 1'b0;
            cfg_q       <= '0;
            pidx_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_err_q    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            wd_cnt_q    <= '0;
            tmo_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            loop_q      <= loop_d;
            dwell_q     <= dwell_d;
            dwell_cnt_q <= dwell_cnt_d;
            stop_pend_q <= stop_pend_d;
            ser_en_q    <= ser_en_d;
            cfg_q       <= cfg_d;
            pidx_q      <= pidx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_err_q    <= wr_err_d;
`ifdef SEQ_TIMEOUT_EN
            wd_cnt_q    <= wd_cnt_d;
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign ser_enable_desp   = ser_en_q;
    assign electr_config_out = cfg_q;
    assign pattern_idx       = pidx_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign wr_err            = wr_err_q;
`ifdef SEQ_TIMEOUT_EN
    assign timeout_err       = tmo_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_electrode_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_electrode_config_sequencer
// Brief    : Directed table-driven bench with a behavioural serializer stub.
//            Define SEQ_TIMEOUT_EN to also exercise the watchdog.
// Revision : 1.0
// ============================================================================
module tb_electrode_config_sequencer;

    localparam int SER_LAT = 10;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0, stop = 1'b0, loop_en = 1'b0, wr_en = 1'b0;
    logic [3:0]  n_patterns_cfg = '0;
    logic [15:0] dwell_cycles = '0;
    logic [2:0]  wr_addr = '0;
    logic [30:0] wr_data = '0;
    logic        ser_sr_finish = 1'b0;
    logic        ser_enable_desp, busy, done, wr_err;
    logic [30:0] electr_config_out;
    logic [2:0]  pattern_idx;
`ifdef SEQ_TIMEOUT_EN
    logic        timeout_err;
    int          tmo_cyc[$];
`endif

    int          n_cmp = 0, n_bad = 0, cyc = 0, fin_cnt = 0, busy_cycles = 0;
    bit          cap_pending = 0, never_finish = 0;
    int          en_cyc[$], fin_cyc[$], done_cyc[$], wr_err_cyc[$], idx_log[$];
    logic        done_busy[$];
    logic [30:0] cap_log[$];
    logic [30:0] tbl [8];

    typedef struct {
        int n; int dw; int stop_mode; bit wr_busy; int exp_cnt; int exp_gap;
    } vec_t;
    vec_t vecs [8];

    electrode_config_sequencer dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .stop(stop), .loop_en(loop_en),
        .n_patterns_cfg(n_patterns_cfg), .dwell_cycles(dwell_cycles),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ser_sr_finish(ser_sr_finish), .ser_enable_desp(ser_enable_desp),
        .electr_config_out(electr_config_out), .pattern_idx(pattern_idx),
        .busy(busy), .done(done), .wr_err(wr_err)
`ifdef SEQ_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 CLK = ~CLK;

    // Serializer stub and event log; cyc numbers the cycle that follows each posedge.
    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (!RST_N) begin
            fin_cnt = 0; cap_pending = 0; ser_sr_finish = 1'b0;
        end else begin
            ser_sr_finish = 1'b0;
            if (cap_pending) begin cap_log.push_back(electr_config_out); cap_pending = 0; end
            if (fin_cnt > 0) begin
                fin_cnt = fin_cnt - 1;
                if (fin_cnt == 0 && !never_finish) begin
                    ser_sr_finish = 1'b1; fin_cyc.push_back(cyc);
                end
            end
            if (ser_enable_desp) begin
                en_cyc.push_back(cyc); idx_log.push_back(int'(pattern_idx));
                cap_pending = 1; fin_cnt = SER_LAT;
            end
            if (done) begin done_cyc.push_back(cyc); done_busy.push_back(busy); end
            if (wr_err) wr_err_cyc.push_back(cyc);
            if (busy) busy_cycles = busy_cycles + 1;
`ifdef SEQ_TIMEOUT_EN
            if (timeout_err) tmo_cyc.push_back(cyc);
`endif
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(); @(negedge CLK); #1; endtask

    task automatic clear_logs();
        en_cyc.delete(); fin_cyc.delete(); done_cyc.delete(); wr_err_cyc.delete();
        idx_log.delete(); done_busy.delete(); cap_log.delete(); busy_cycles = 0;
`ifdef SEQ_TIMEOUT_EN
        tmo_cyc.delete();
`endif
    endtask

    task automatic wr(input int a, input logic [30:0] d);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = d; step(); wr_en = 1'b0;
    endtask

    task automatic pulse_start(input int n, input int dw, input bit lp, input bit stp,
                               output int s_cyc);
        n_patterns_cfg = 4'(n); dwell_cycles = 16'(dw); loop_en = lp;
        start = 1'b1; stop = stp; s_cyc = cyc;
        step();
        start = 1'b0; stop = 1'b0;
        // Scrambled config after acceptance must not affect a running scan.
        n_patterns_cfg = 4'd1; dwell_cycles = 16'd7; loop_en = ~lp;
    endtask

    task automatic wait_done(input int budget);
        for (int t = 0; t < budget && done_cyc.size() == 0; t++) step();
        for (int t = 0; t < 3; t++) step();
    endtask

    task automatic run_vec(input vec_t v);
        int s_cyc, w_cyc;
        clear_logs();
        w_cyc = 0;
        if (v.stop_mode == 2) begin stop = 1'b1; step(); stop = 1'b0; end
        pulse_start(v.n, v.dw, 1'b0, v.stop_mode == 1, s_cyc);
        if (v.wr_busy) begin
            for (int t = 0; t < 50 && en_cyc.size() == 0; t++) step();
            w_cyc = cyc;
            wr(1, 31'h0ABC_DEF0);
        end
        if (v.exp_cnt == 0) for (int t = 0; t < 20; t++) step();
        else wait_done(3000);
        chk("enable_count", en_cyc.size(), v.exp_cnt);
        chk("done_count", done_cyc.size(), (v.exp_cnt > 0) ? 1 : 0);
        chk("busy_idle_after", busy, 0);
        chk("wr_err_count", wr_err_cyc.size(), v.wr_busy ? 1 : 0);
        if (v.wr_busy && wr_err_cyc.size() > 0) chk("wr_err_cycle", wr_err_cyc[0], w_cyc + 1);
        if (v.exp_cnt == 0) chk("busy_never_set", busy_cycles, 0);
        if (en_cyc.size() > 0) chk("start_latency", en_cyc[0] - s_cyc, 2);
        for (int i = 0; i < v.exp_cnt && i < en_cyc.size() && i < cap_log.size(); i++) begin
            chk($sformatf("pattern_word[%0d]", i), cap_log[i], tbl[i]);
            chk($sformatf("pattern_idx[%0d]", i), idx_log[i], i);
            if (i > 0 && i - 1 < fin_cyc.size())
                chk($sformatf("finish_gap[%0d]", i), en_cyc[i] - fin_cyc[i-1], v.exp_gap);
        end
        if (done_cyc.size() > 0 && v.exp_cnt > 0 && fin_cyc.size() >= v.exp_cnt) begin
            chk("done_after_finish", done_cyc[0] - fin_cyc[v.exp_cnt-1], v.exp_gap - 1);
            chk("busy_at_done", done_busy[0], 0);
        end
    endtask

    initial begin
        int s_cyc;
        tbl[0] = 31'h0000_0001; tbl[1] = 31'h5555_5555; tbl[2] = 31'h7FFF_FFFF;
        tbl[3] = 31'h0123_4567; tbl[4] = 31'h2AAA_AAAA; tbl[5] = 31'h0F0F_0F0F;
        tbl[6] = 31'h7000_0001; tbl[7] = 31'h1234_5678;
        //          n   dw  stop wr_busy cnt gap
        vecs[0] = '{3,  4,  0,   0,      3,  7};
        vecs[1] = '{3,  0,  0,   0,      3,  4};
        vecs[2] = '{2,  10, 0,   0,      2,  13};
        vecs[3] = '{15, 1,  0,   0,      8,  4};
        vecs[4] = '{0,  3,  0,   0,      0,  0};
        vecs[5] = '{2,  0,  1,   0,      2,  4};
        vecs[6] = '{3,  2,  2,   1,      3,  5};
        vecs[7] = '{8,  2,  0,   0,      8,  5};

        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_enable", ser_enable_desp, 0);
        chk("rst_config", electr_config_out, 0);
        chk("rst_idx", pattern_idx, 0);
        chk("rst_done_wrerr", {done, wr_err}, 0);
        RST_N = 1'b1; step();

        clear_logs();
        for (int i = 0; i < 8; i++) wr(i, tbl[i]);
        step();
        chk("idle_write_no_err", wr_err_cyc.size(), 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Looping scan, stop during the second pattern of the second pass.
        clear_logs();
        pulse_start(2, 1, 1'b1, 1'b0, s_cyc);
        for (int t = 0; t < 500 && en_cyc.size() < 4; t++) step();
        stop = 1'b1; step(); stop = 1'b0;
        wait_done(500);
        chk("loop_enable_count", en_cyc.size(), 4);
        chk("loop_finish_count", fin_cyc.size(), 4);
        chk("loop_done_count", done_cyc.size(), 1);
        for (int i = 0; i < 4 && i < idx_log.size(); i++)
            chk($sformatf("loop_idx[%0d]", i), idx_log[i], i % 2);
        if (cap_log.size() == 4) chk("loop_last_word", cap_log[3], tbl[1]);
        if (done_cyc.size() > 0 && fin_cyc.size() == 4)
            chk("stop_done_after_finish", done_cyc[0] - fin_cyc[3], 1);

        // Asynchronous reset while waiting on the serializer.
        clear_logs();
        pulse_start(3, 0, 1'b0, 1'b0, s_cyc);
        for (int t = 0; t < 50 && en_cyc.size() == 0; t++) step();
        step(); step();
        chk("pre_reset_busy", busy, 1);
        RST_N = 1'b0; #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_config", electr_config_out, 0);
        chk("async_rst_idx_en", {pattern_idx, ser_enable_desp, done}, 0);
        step(); step();
        RST_N = 1'b1;
        for (int t = 0; t < 5; t++) step();
        chk("post_reset_idle", busy, 0);
        chk("post_reset_no_done", done_cyc.size(), 0);
        run_vec(vecs[1]);

`ifdef SEQ_TIMEOUT_EN
        clear_logs();
        never_finish = 1;
        pulse_start(1, 0, 1'b0, 1'b0, s_cyc);
        wait_done(300);
        never_finish = 0;
        chk("tmo_done_count", done_cyc.size(), 1);
        chk("tmo_err_count", tmo_cyc.size(), 1);
        if (done_cyc.size() > 0 && en_cyc.size() > 0)
            chk("tmo_done_delay", done_cyc[0] - en_cyc[0], 71);
        if (done_cyc.size() > 0 && tmo_cyc.size() > 0)
            chk("tmo_with_done", tmo_cyc[0], done_cyc[0]);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
